geofence_tally: RTL
===================

# geofence_tally

Result collector directly downstream of the geofence engine. Consumes the engine's one-cycle `valid`/`is_inside` result pulses, packs consecutive results LSB-first into bytes, and queues them in a small FIFO. The FIFO drains through a valid/ready handshake to the host-side readout. Optionally keeps saturating inside/total statistics counters.

## Interface
- `FIFO_DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `CNT_W`, default 16: width of the statistics counters.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `gf_valid`  in  1  result strobe from the geofence engine; one cycle per result.
- `gf_inside`  in  1  result bit; sampled only when `gf_valid`=1.
- `flush`  in  1  pulse; pushes the partially packed byte.
- `out_ready`  in  1  consumer accepts the FIFO head.
- `out_valid`  out  1  FIFO non-empty.
- `out_data`  out  8  FIFO head byte; result k of the byte is in bit k.
- `out_len`  out  4  number of valid bits in `out_data`, 1..8.
- `overflow`  out  1  sticky flag; a byte was dropped because the FIFO was full.
- `inside_cnt`  out  CNT_W  saturating count of results with `gf_inside`=1.
- `total_cnt`  out  CNT_W  saturating count of all results.

## Operation
- Pack register: 8-bit `pack` plus 4-bit `nbits` (0..8). On each sampled `gf_valid`, `gf_inside` is written to `pack[nbits]` and `nbits` increments.
- Push condition, evaluated after the current bit is included: `nbits` reaches 8, or `flush`=1 with `nbits`>0. On push, the entry {`pack`, `nbits`} is written to the FIFO. Bits above `nbits` are 0. `pack` and `nbits` then clear.
- `flush` with `nbits`=0 and no `gf_valid` pushes nothing. `flush` together with the 8th result produces a single push with length 8.
- Pop: `out_valid` && `out_ready` removes the head entry.
- Full FIFO: a push in the same cycle as a pop is accepted. A push without a pop is dropped: `overflow` sets and stays set until reset, and `pack`/`nbits` still clear.
- FIFO state: pointer-based, with `count` of width log2(FIFO_DEPTH)+1. Read/write pointers wrap modulo FIFO_DEPTH.
- Statistics: on each sampled `gf_valid`, `total_cnt` increments and `inside_cnt` increments if `gf_inside`=1. Both saturate at all-ones. They are independent of FIFO state and are not affected by drops.
- Control FSM:
  - EMPTY: `count`=0.
  - PARTIAL: 0<`count`<FIFO_DEPTH.
  - FULL: `count`=FIFO_DEPTH.
  - EMPTY→PARTIAL on a push without a pop.
  - PARTIAL→FULL when a push without a pop brings `count` to FIFO_DEPTH.
  - FULL→PARTIAL on a pop without a push.
  - PARTIAL→EMPTY on the last pop without a push.
  - All other combinations hold the current state.

## Timing
- Reset (asynchronous, immediate), all outputs: `out_valid`=0, `out_data`=0, `out_len`=0, `overflow`=0, `inside_cnt`=0, `total_cnt`=0. Pack register, pointers and FIFO state are also cleared.
- Reset mid-frame discards partially packed bits and all queued entries. No output glitch appears after reset deasserts.
- Latency: a push at rising edge E makes `out_valid`=1 in the cycle after E, provided the FIFO was empty. Counters reflect a result one cycle after its `gf_valid` cycle.
- `out_data`/`out_len` are combinational reads of the head entry. They are stable while `out_valid`=1 and `out_ready`=0.
- `out_valid` never deasserts without a pop. It does not depend on `out_ready`.
- Sustained rate: one result per cycle into the packer; one pop per cycle out.

## Configuration
- `GEOFENCE_TALLY_STATS_EN` defined: `inside_cnt`/`total_cnt` registers are built as described.
- Undefined: no counter registers are built; `inside_cnt` and `total_cnt` are tied to 0. Packing, FIFO and `overflow` behaviour are unchanged.

## Test plan
- Pack a full byte: 8 results 1,0,1,1,0,0,0,1 with `out_ready`=1 → one entry `out_data`=0x8D, `out_len`=8, `out_valid` high exactly one cycle after the 8th strobe.
- Flush a partial byte: results 1,1,0, then `flush` → `out_data`=0x03, `out_len`=3. A second `flush` with no new results → no entry.
- Flush coincident with the 8th result: 8 results all 1 with `flush` on the 8th strobe → exactly one entry, 0xFF, length 8.
- Overflow: `out_ready`=0, 40 results → 4 entries queued, `overflow`=1 after the 5th byte. Then `out_ready`=1 → exactly 4 pops of the first 4 bytes, in order.
- Full with simultaneous push and pop: FIFO full, `out_ready`=1 in the cycle the next byte completes → push accepted, `count` stays 4, `overflow` stays 0.
- Statistics (macro defined, `CNT_W`=4): 20 inside results → `inside_cnt`=15, `total_cnt`=15. Reset mid-stream → all outputs 0 immediately. Macro undefined → counters read 0 throughout.

Source files
------------

// File: rtl/geofence_tally_if.sv
// Result/readout bundle between the geofence engine, the tally block and the
// host-side readout. The tally block sits on the slave side.
interface geofence_tally_if #(
  parameter int CNT_W = 16
);
  logic             gf_valid;
  logic             gf_inside;
  logic             flush;
  logic             out_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic [3:0]       out_len;
  logic             overflow;
  logic [CNT_W-1:0] inside_cnt;
  logic [CNT_W-1:0] total_cnt;

  modport master (
    output gf_valid, gf_inside, flush, out_ready,
    input  out_valid, out_data, out_len, overflow, inside_cnt, total_cnt
  );

  modport slave (
    input  gf_valid, gf_inside, flush, out_ready,
    output out_valid, out_data, out_len, overflow, inside_cnt, total_cnt
  );
endinterface

// File: rtl/geofence_tally.sv
// geofence_tally: packs geofence result bits LSB-first into bytes, queues
// {byte, length} entries in a small FIFO drained by valid/ready, and flags
// dropped bytes with a sticky overflow bit.
// Optional statistics counters are built when GEOFENCE_TALLY_STATS_EN is
// defined; otherwise inside_cnt/total_cnt are tied to zero.
module geofence_tally #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input logic             clk,
  input logic             reset,
  geofence_tally_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] len;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  state_t        state, state_nxt;
  logic [7:0]    pack, pack_upd;
  logic [3:0]    nbits, nbits_upd;
  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          push, pop, wr_en;

  // Fold the current result into the pack register before deciding to push,
  // so a flush on the 8th strobe yields one length-8 entry.
  always_comb begin
    pack_upd  = pack;
    nbits_upd = nbits;
    if (bus.gf_valid) begin
      pack_upd[nbits[2:0]] = bus.gf_inside;
      nbits_upd            = nbits + 4'd1;
    end
  end

  assign push  = (nbits_upd == 4'd8) || (bus.flush && (nbits_upd != 4'd0));
  assign pop   = bus.out_valid && bus.out_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign wr_en = push && ((state != FULL) || pop);

  // Pack register; clears on every push, accepted or dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pack  <= '0;
      nbits <= '0;
    end else if (push) begin
      pack  <= '0;
      nbits <= '0;
    end else begin
      pack  <= pack_upd;
      nbits <= nbits_upd;
    end
  end

  // FIFO storage, pointers (wrap naturally at power-of-two depth) and count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= '{data: pack_upd, len: nbits_upd};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 bus.overflow <= 1'b0;
    else if (push && !wr_en)   bus.overflow <= 1'b1;
  end

  // Occupancy state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Occupancy transitions; simultaneous push and pop holds the state.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (wr_en && !pop) state_nxt = PARTIAL;
      PARTIAL: begin
        if (wr_en && !pop && (count == CNT_LAST))   state_nxt = FULL;
        else if (pop && !wr_en && (count == 'd1))   state_nxt = EMPTY;
      end
      FULL:    if (pop && !wr_en) state_nxt = PARTIAL;
      default: state_nxt = EMPTY;
    endcase
  end

  assign bus.out_valid = (state != EMPTY);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr].data : 8'd0;
  assign bus.out_len   = bus.out_valid ? mem[rd_ptr].len  : 4'd0;

`ifdef GEOFENCE_TALLY_STATS_EN
  logic [CNT_W-1:0] ins_q, tot_q;

  // Saturating statistics; independent of FIFO acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ins_q <= '0;
      tot_q <= '0;
    end else if (bus.gf_valid) begin
      if (tot_q != '1)                   tot_q <= tot_q + 1'b1;
      if (bus.gf_inside && (ins_q != '1)) ins_q <= ins_q + 1'b1;
    end
  end

  assign bus.inside_cnt = ins_q;
  assign bus.total_cnt  = tot_q;
`else
  assign bus.inside_cnt = '0;
  assign bus.total_cnt  = '0;
`endif
endmodule
